// File: rtl/uart_loader.sv
// uart_loader: serial bootloader / command engine between the UART rx and tx FIFOs.
// It parses frames of the form SYNC, CMD, ADDR[4] LE, LEN[2] LE, DATA[LEN], CSUM.
//   CMD 0x01 writes the data bytes to memory.
//   CMD 0x02 requests a jump and must have LEN = 0.
//   Any other CMD is parsed to the end of the frame and then answered with NAK.
// Every complete frame is answered with one ACK or NAK byte.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rx_data/rx_pop/rx_ack
//                      rx FIFO head byte, loader request, byte consumed
//   tx_data/tx_available/tx_ack
//                      response byte, response pending, response accepted
//   mem_valid/mem_addr/mem_wdata/mem_wstrb/mem_ready
//                      byte-lane write port
//   busy               a frame is in progress (state != IDLE)
//   go, boot_addr      one-cycle pulse on an accepted jump, and its target
module uart_loader #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  output logic                  rx_pop,
  input  logic                  rx_ack,
  output logic [7:0]            tx_data,
  output logic                  tx_available,
  input  logic                  tx_ack,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  go,
  output logic [ADDR_WIDTH-1:0] boot_addr
);

  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  CMD_WRITE = 8'h01;
  localparam logic [7:0]  CMD_JUMP  = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_MEMWR, S_CSUM, S_RESP
  } state_t;

  state_t                r_state;
  logic [7:0]            r_cmd;
  logic [7:0]            r_sum;
  logic [7:0]            r_len_lo;
  logic                  r_len_nz;
  logic [23:0]           r_araw;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_rem;
  logic [1:0]            r_idx;
  logic [TMO_W-1:0]      r_tmo;

  logic                  w_take;
  logic                  w_timed;
  logic                  w_tmo_hit;
  logic                  w_good;
  logic [7:0]            w_sum_next;
  logic [15:0]           w_len;
  logic [TMO_W-1:0]      w_tmo_next;

  assign rx_pop     = !rst && (r_state inside {S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_CSUM});
  assign busy       = (r_state != S_IDLE);
  assign w_take     = rx_ack && rx_pop;
  // The inter-byte timeout only runs while waiting for rx bytes inside a frame.
  assign w_timed    = r_state inside {S_CMD, S_ADDR, S_LEN, S_DATA, S_CSUM};
  assign w_tmo_next = r_tmo + TMO_W'(1);
  assign w_tmo_hit  = (w_tmo_next == TMO_W'(TIMEOUT_CYCLES));
  assign w_sum_next = r_sum + rx_data;
  assign w_len      = {rx_data, r_len_lo};
  // Judged in the CSUM cycle: w_sum_next then includes the checksum byte.
  assign w_good     = (w_sum_next == 8'h00) &&
                      ((r_cmd == CMD_WRITE) || ((r_cmd == CMD_JUMP) && !r_len_nz));

  // Frame parser, memory write handshake, response and jump signalling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cmd        <= 8'h00;
      r_sum        <= 8'h00;
      r_len_lo     <= 8'h00;
      r_len_nz     <= 1'b0;
      r_araw       <= 24'h0;
      r_addr       <= '0;
      r_rem        <= 16'h0;
      r_idx        <= 2'd0;
      r_tmo        <= '0;
      tx_data      <= 8'h00;
      tx_available <= 1'b0;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'h0;
      mem_wstrb    <= 4'h0;
      go           <= 1'b0;
      boot_addr    <= '0;
    end else begin
      go <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_take && (rx_data == SYNC_BYTE)) begin
            r_sum   <= 8'h00;
            r_state <= S_CMD;
          end
        end
        S_CMD: begin
          if (w_take) begin
            r_cmd   <= rx_data;
            r_sum   <= w_sum_next;
            r_idx   <= 2'd0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_take) begin
            r_sum  <= w_sum_next;
            r_idx  <= r_idx + 2'd1;
            // Little-endian: shift the first three bytes in, then load the full address.
            r_araw <= {rx_data, r_araw[23:8]};
            if (r_idx == 2'd3) begin
              r_addr  <= ADDR_WIDTH'({rx_data, r_araw});
              r_idx   <= 2'd0;
              r_state <= S_LEN;
            end
          end
        end
        S_LEN: begin
          if (w_take) begin
            r_sum <= w_sum_next;
            if (!r_idx[0]) begin
              r_len_lo <= rx_data;
              r_idx    <= 2'd1;
            end else begin
              r_rem    <= w_len;
              r_len_nz <= (w_len != 16'h0);
              r_state  <= (w_len == 16'h0) ? S_CSUM : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_take) begin
            r_sum <= w_sum_next;
            if (r_cmd == CMD_WRITE) begin
              mem_valid <= 1'b1;
              mem_addr  <= {r_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= {4{rx_data}};
              mem_wstrb <= 4'b0001 << r_addr[1:0];
              r_state   <= S_MEMWR;
            end else begin
              // Jump or unknown command: data is only counted.
              r_rem   <= r_rem - 16'd1;
              r_state <= (r_rem == 16'd1) ? S_CSUM : S_DATA;
            end
          end
        end
        S_MEMWR: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            r_addr    <= r_addr + ADDR_WIDTH'(1);
            r_rem     <= r_rem - 16'd1;
            r_state   <= (r_rem == 16'd1) ? S_CSUM : S_DATA;
          end
        end
        S_CSUM: begin
          if (w_take) begin
            tx_data      <= w_good ? ACK_BYTE : NAK_BYTE;
            tx_available <= 1'b1;
            if (w_good && (r_cmd == CMD_JUMP)) begin
              go        <= 1'b1;
              boot_addr <= r_addr;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (tx_ack) begin
            tx_available <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Inter-byte timeout: abandon the frame silently. This overrides the case above.
      if (w_timed) begin
        if (w_take) begin
          r_tmo <= '0;
        end else if (w_tmo_hit) begin
          r_tmo   <= '0;
          r_state <= S_IDLE;
        end else begin
          r_tmo <= w_tmo_next;
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: self-checking bench for uart_loader.
// A frame-level reference model turns each byte stream into the expected writes,
// responses and jump targets. One monitor compares DUT activity against the model
// every cycle, and a handful of literal checks pin the model itself.
module tb_uart_loader;

  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_pop;
  logic          rx_ack = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_available;
  logic          tx_ack = 1'b0;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready = 1'b0;
  logic          busy;
  logic          go;
  logic [AW-1:0] boot_addr;

  always #5 clk = ~clk;

  uart_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_pop(rx_pop), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_available(tx_available), .tx_ack(tx_ack),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .busy(busy), .go(go), .boot_addr(boot_addr)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [7:0]  exp_resp[$];
  logic [31:0] exp_jump[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  frm[$];

  int n_checks = 0;
  int n_pass   = 0;
  int wr_seen  = 0;
  int go_seen  = 0;
  int resp_seen = 0;
  logic [7:0] last_resp = 8'h00;
  int mem_hold = 0;   // -1: random mem_ready, else cycles held low per write
  int tx_hold  = 0;   // -1: random tx_ack, else cycles held low per response

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference model: parse whole frames out of frm and queue what must happen.
  task automatic model_frm();
    int i = 0;
    int n = frm.size();
    while (i < n) begin
      logic [7:0]  cmd;
      logic [31:0] addr;
      int          len;
      logic [7:0]  s;
      bit          good;
      if (frm[i] != 8'hA5) begin i++; continue; end
      if (i + 8 > n) break;
      cmd  = frm[i+1];
      addr = {frm[i+5], frm[i+4], frm[i+3], frm[i+2]};
      len  = int'({frm[i+7], frm[i+6]});
      if (i + 9 + len > n) break;
      s = 8'h00;
      for (int j = i + 1; j <= i + 8 + len; j++) s = s + frm[j];
      good = (s == 8'h00) && ((cmd == 8'h01) || ((cmd == 8'h02) && (len == 0)));
      if (cmd == 8'h01) begin
        for (int k = 0; k < len; k++) begin
          logic [31:0] a;
          wr_t w;
          a = addr + 32'(k);
          w.addr = {a[31:2], 2'b00};
          w.strb = 4'b0001 << a[1:0];
          w.data = {4{frm[i+8+k]}};
          exp_wr.push_back(w);
        end
      end
      exp_resp.push_back(good ? 8'h06 : 8'h15);
      if (good && (cmd == 8'h02)) exp_jump.push_back(addr);
      i = i + 9 + len;
    end
  endtask

  task automatic enqueue();
    foreach (frm[k]) rx_q.push_back(frm[k]);
  endtask

  task automatic cyc();
    @(negedge clk);
    #3;
  endtask

  task automatic drain();
    int k = 0;
    while (k < 5000 && !(rx_q.size() == 0 && !busy && exp_wr.size() == 0 &&
                         exp_resp.size() == 0 && exp_jump.size() == 0)) begin
      cyc();
      k++;
    end
    check("drain_in_time", 128'(k < 5000), 128'(1));
    cyc();
    check("expectations_left", 128'(exp_wr.size() + exp_resp.size() + exp_jump.size()), 128'(0));
  endtask

  task automatic plan_write();
    frm = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h95};
  endtask

  // Stimulus driver: rx FIFO, memory and tx sinks (inputs change 1 time unit after negedge).
  initial begin
    int mem_wait = 0;
    int tx_wait  = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rx_ack && rx_q.size() > 0) void'(rx_q.pop_front());
      rx_ack  = rx_pop && (rx_q.size() > 0) && ($urandom_range(0, 3) != 0);
      rx_data = rx_ack ? rx_q[0] : 8'($urandom);
      if (mem_valid) mem_wait++; else mem_wait = 0;
      if (mem_hold < 0) mem_ready = ($urandom_range(0, 1) == 1);
      else              mem_ready = mem_valid && (mem_wait > mem_hold);
      if (tx_available) tx_wait++; else tx_wait = 0;
      if (tx_hold < 0) tx_ack = tx_available && ($urandom_range(0, 1) == 1);
      else             tx_ack = tx_available && (tx_wait > tx_hold);
    end
  end

  // Compare process: every cycle, against the model and the handshake rules.
  initial begin
    bit          p_mv = 0, p_mhs = 0, p_tv = 0, p_ths = 0, p_go = 0;
    logic [67:0] p_req = '0;
    logic [7:0]  p_tx = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        p_mv = 0; p_mhs = 0; p_tv = 0; p_ths = 0; p_go = 0;
        continue;
      end
      if (rx_ack) check("rx_ack_needs_pop", 128'(rx_pop), 128'(1));
      if (mem_valid || tx_available) check("rx_pop_low", 128'(rx_pop), 128'(0));
      if (mem_valid) check("busy_in_write", 128'(busy), 128'(1));
      if (p_mv && !p_mhs)
        check("mem_req_stable", 128'({mem_valid, mem_addr, mem_wstrb, mem_wdata}), 128'({1'b1, p_req}));
      if (p_tv && !p_ths)
        check("tx_stable", 128'({tx_available, tx_data}), 128'({1'b1, p_tx}));
      if (p_ths) check("busy_after_tx", 128'(busy), 128'(0));
      if (p_go) check("go_pulse", 128'(go), 128'(0));
      if (mem_valid && mem_ready) begin
        wr_seen++;
        if (exp_wr.size() == 0) check("wr_unexpected", 128'(mem_valid), 128'(0));
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("mem_write", 128'({mem_addr, mem_wstrb, mem_wdata}), 128'(e));
        end
      end
      if (tx_available && tx_ack) begin
        resp_seen++;
        last_resp = tx_data;
        if (exp_resp.size() == 0) check("resp_unexpected", 128'(tx_available), 128'(0));
        else begin
          logic [7:0] r;
          r = exp_resp.pop_front();
          check("tx_resp", 128'(tx_data), 128'(r));
        end
      end
      if (go) begin
        go_seen++;
        check("go_with_ack", 128'({tx_available, tx_data}), 128'({1'b1, 8'h06}));
        if (exp_jump.size() == 0) check("go_unexpected", 128'(go), 128'(0));
        else begin
          logic [31:0] j;
          j = exp_jump.pop_front();
          check("boot_addr", 128'(boot_addr), 128'(j));
        end
      end
      p_mv  = mem_valid;
      p_mhs = mem_valid && mem_ready;
      p_req = {mem_addr, mem_wstrb, mem_wdata};
      p_tv  = tx_available;
      p_ths = tx_available && tx_ack;
      p_tx  = tx_data;
      p_go  = go;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0, g0, r0, k;
    rst = 1'b1;
    repeat (3) cyc();
    check("rst_outputs", 128'({mem_valid, tx_available, go, busy, rx_pop}), 128'(0));
    check("rst_regs", 128'({mem_addr, mem_wdata, mem_wstrb, tx_data}), 128'(0));
    check("rst_boot_addr", 128'(boot_addr), 128'(0));
    rst = 1'b0;
    cyc();

    // Good write frame.
    plan_write();
    model_frm();
    check("model_nwr", 128'(exp_wr.size()), 128'(3));
    if (exp_wr.size() == 3) begin
      check("model_wr0", 128'(exp_wr[0]), 128'({32'h100, 4'b0001, 32'h11111111}));
      check("model_wr1", 128'(exp_wr[1]), 128'({32'h100, 4'b0010, 32'h22222222}));
      check("model_wr2", 128'(exp_wr[2]), 128'({32'h100, 4'b0100, 32'h33333333}));
    end
    if (exp_resp.size() == 1) check("model_ack", 128'(exp_resp[0]), 128'(8'h06));
    w0 = wr_seen;
    enqueue();
    drain();
    check("write_count", 128'(wr_seen - w0), 128'(3));

    // Bad checksum: writes still happen, response is NAK.
    plan_write();
    frm[11] = 8'h96;
    model_frm();
    if (exp_resp.size() == 1) check("model_nak", 128'(exp_resp[0]), 128'(8'h15));
    w0 = wr_seen; g0 = go_seen;
    enqueue();
    drain();
    check("badsum_writes", 128'(wr_seen - w0), 128'(3));
    check("badsum_no_go", 128'(go_seen - g0), 128'(0));

    // Jump.
    frm = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h7E};
    model_frm();
    if (exp_jump.size() == 1) check("model_jump", 128'(exp_jump[0]), 128'(32'h80000000));
    w0 = wr_seen; g0 = go_seen;
    enqueue();
    drain();
    check("jump_go_once", 128'(go_seen - g0), 128'(1));
    check("jump_no_write", 128'(wr_seen - w0), 128'(0));
    check("jump_boot_addr", 128'(boot_addr), 128'(32'h80000000));

    // Noise before a valid frame.
    frm = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h95};
    model_frm();
    w0 = wr_seen;
    enqueue();
    drain();
    check("noise_writes", 128'(wr_seen - w0), 128'(3));

    // Jump with LEN=1 and a correct checksum.
    frm = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h80, 8'h01, 8'h00, 8'h00, 8'h7D};
    model_frm();
    if (exp_resp.size() == 1) check("model_jump_len_nak", 128'(exp_resp[0]), 128'(8'h15));
    g0 = go_seen;
    enqueue();
    drain();
    check("jump_len_no_go", 128'(go_seen - g0), 128'(0));

    // Memory and tx backpressure.
    mem_hold = 20;
    plan_write(); model_frm(); enqueue(); drain();
    mem_hold = 0;
    tx_hold = 50;
    plan_write(); model_frm(); enqueue(); drain();
    tx_hold = 0;

    // Timeout after the address bytes.
    frm = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00};
    r0 = resp_seen;
    enqueue();
    k = 0;
    while (rx_q.size() != 0 && k < 1000) begin cyc(); k++; end
    check("tmo_bytes_taken", 128'(rx_q.size()), 128'(0));
    for (int c = 1; c <= 101; c++) begin
      if (c == 100) check("tmo_busy_before_limit", 128'(busy), 128'(1));
      if (c == 101) check("tmo_idle_at_limit", 128'(busy), 128'(0));
      if (c < 101) cyc();
    end
    check("tmo_no_resp", 128'({tx_available, 32'(resp_seen - r0)}), 128'(0));
    plan_write(); model_frm(); enqueue(); drain();

    // Reset in the middle of a held write.
    mem_hold = 100000;
    plan_write();
    enqueue();
    k = 0;
    while (!mem_valid && k < 1000) begin cyc(); k++; end
    check("reached_memwr", 128'(mem_valid), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    rx_q.delete();
    exp_wr.delete(); exp_resp.delete(); exp_jump.delete();
    #3;
    cyc();
    check("rst_mid_write", 128'({mem_valid, busy, rx_pop, tx_available}), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    mem_hold = 0;
    #3;
    plan_write(); model_frm();
    r0 = resp_seen;
    enqueue();
    drain();
    check("post_reset_resp", 128'({32'(resp_seen - r0), last_resp}), 128'({32'd1, 8'h06}));

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      int          r, len, nn;
      logic [7:0]  cmd, s, b;
      logic [31:0] addr;
      mem_hold = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 4));
      tx_hold  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 3));
      frm.delete();
      nn = int'($urandom_range(0, 2));
      for (int i = 0; i < nn; i++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        frm.push_back(b);
      end
      r = int'($urandom_range(0, 9));
      cmd = (r < 6) ? 8'h01 : (r < 8) ? 8'h02 : ((r == 8) ? 8'h03 : 8'hFF);
      if (cmd == 8'h02) len = ($urandom_range(0, 3) == 0) ? 1 : 0;
      else              len = int'($urandom_range(0, 6));
      addr = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFD : $urandom;
      frm.push_back(8'hA5);
      frm.push_back(cmd);
      for (int i = 0; i < 4; i++) frm.push_back(addr[8*i +: 8]);
      frm.push_back(8'(len));
      frm.push_back(8'h00);
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
      s = 8'h00;
      for (int i = nn + 1; i < frm.size(); i++) s = s + frm[i];
      s = 8'h00 - s;
      if ($urandom_range(0, 4) == 0) s = s + 8'h01;
      frm.push_back(s);
      model_frm();
      enqueue();
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
